// File: rtl/seq_mag_comp.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, early exit on first unequal digit.
// Optional macro SEQ_MAG_COMP_SIGNED_EN selects two's-complement comparison via offset-binary capture.
module seq_mag_comp #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             G,
  output logic             L,
  output logic             E
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_xr;
  logic [WIDTH-1:0] r_yr;
  logic [IW-1:0]    r_idx;
  logic             r_g;
  logic             r_l;
  logic             r_e;

  logic [WIDTH-1:0] w_xin;
  logic [WIDTH-1:0] w_yin;
  logic [DIGIT-1:0] w_xd;
  logic [DIGIT-1:0] w_yd;
  logic             w_load;
  logic             w_dec;
  logic             w_set_g;
  logic             w_set_l;
  logic             w_set_e;

`ifdef SEQ_MAG_COMP_SIGNED_EN
  // Flipping the sign bit maps two's complement onto offset binary, so the unsigned digit walk orders signed values.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  always_comb begin
    w_xin = x ^ MSB_MASK;
    w_yin = y ^ MSB_MASK;
  end
`else
  always_comb begin
    w_xin = x;
    w_yin = y;
  end
`endif

  always_comb begin
    w_xd = r_xr[r_idx*DIGIT +: DIGIT];
    w_yd = r_yr[r_idx*DIGIT +: DIGIT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_set_g    = 1'b0;
    w_set_l    = 1'b0;
    w_set_e    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load     = 1'b1;
          w_state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (w_xd > w_yd) begin
          w_set_g    = 1'b1;
          w_state_nx = S_DONE;
        end else if (w_xd < w_yd) begin
          w_set_l    = 1'b1;
          w_state_nx = S_DONE;
        end else if (r_idx == '0) begin
          w_set_e    = 1'b1;
          w_state_nx = S_DONE;
        end else begin
          w_dec      = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          w_load     = 1'b1;
          w_state_nx = S_RUN;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xr  <= '0;
      r_yr  <= '0;
      r_idx <= '0;
      r_g   <= 1'b0;
      r_l   <= 1'b0;
      r_e   <= 1'b0;
    end else begin
      if (w_load) begin
        r_xr  <= w_xin;
        r_yr  <= w_yin;
        r_idx <= IW'(NDIG - 1);
        r_g   <= 1'b0;
        r_l   <= 1'b0;
        r_e   <= 1'b0;
      end else begin
        if (w_dec)   r_idx <= r_idx - IW'(1);
        if (w_set_g) r_g   <= 1'b1;
        if (w_set_l) r_l   <= 1'b1;
        if (w_set_e) r_e   <= 1'b1;
      end
    end
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
    G    = r_g;
    L    = r_l;
    E    = r_e;
  end

endmodule

// File: tb/tb_seq_mag_comp.sv
// Directed table-driven bench for seq_mag_comp (WIDTH=16, DIGIT=2), with hand-written handshake/reset sequences.
module tb_seq_mag_comp;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] x;
  logic [15:0] y;
  logic        busy;
  logic        done;
  logic        G;
  logic        L;
  logic        E;

  int total;
  int bad;

  seq_mag_comp #(.WIDTH(16), .DIGIT(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .G     (G),
    .L     (L),
    .E     (E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    int          m;
    logic        g;
    logic        l;
    logic        e;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive start for one edge from the current point (must be before the next posedge).
  task automatic launch_now(input logic [15:0] xa, input logic [15:0] ya);
    start = 1'b1;
    x     = xa;
    y     = ya;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic launch(input logic [15:0] xa, input logic [15:0] ya);
    @(negedge clk);
    launch_now(xa, ya);
  endtask

  // Returns the edge number (edge 0 = start acceptance) at which done appeared, -1 on timeout.
  task automatic wait_done(output int cyc, output int busy_bad);
    cyc      = -1;
    busy_bad = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = c;
        break;
      end
      if (!busy) busy_bad++;
    end
  endtask

  task automatic check_op(input string tag, input vec_t v);
    int cyc;
    int bb;
    launch(v.x, v.y);
    chk({tag, "_busy0"}, {29'd0, busy, done, G | L | E}, 32'h4);
    wait_done(cyc, bb);
    chk({tag, "_lat"}, cyc, v.m);
    chk({tag, "_busyrun"}, bb, 0);
    chk({tag, "_flags"}, {28'd0, busy, G, L, E}, {28'd0, 1'b0, v.g, v.l, v.e});
  endtask

  initial begin
    int cyc;
    int bb;
    int ndone;
    int first;
    total = 0;
    bad   = 0;
    start = 1'b0;
    x     = '0;
    y     = '0;
    rst   = 1'b0;

    vt[0]  = '{16'h1234, 16'h1234, 8, 1'b0, 1'b0, 1'b1};
`ifdef SEQ_MAG_COMP_SIGNED_EN
    vt[1]  = '{16'h8000, 16'h7FFF, 1, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{16'h0000, 16'hFFFF, 1, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{16'hFFFF, 16'h0001, 1, 1'b0, 1'b1, 1'b0};
`else
    vt[1]  = '{16'h8000, 16'h7FFF, 1, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{16'h0000, 16'hFFFF, 1, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{16'hFFFF, 16'h0001, 1, 1'b1, 1'b0, 1'b0};
`endif
    vt[2]  = '{16'h00FE, 16'h00FF, 8, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{16'h0003, 16'h0001, 8, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{16'h0400, 16'h0800, 3, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{16'hC000, 16'h8000, 1, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{16'hFFFE, 16'hFFFF, 8, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{16'h0000, 16'h0000, 8, 1'b0, 1'b0, 1'b1};
    vt[10] = '{16'h0030, 16'h0020, 6, 1'b1, 1'b0, 1'b0};

    #1 rst = 1'b1;
    #1;
    chk("reset_outs", {27'd0, busy, done, G, L, E}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Scenario 1 plus flag hold after done
    check_op("s1", vt[0]);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("s1_hold", {27'd0, busy, done, G, L, E}, 32'h1);
    end

    foreach (vt[i]) check_op($sformatf("vec%0d", i), vt[i]);

    // Back-to-back: start held in the DONE cycle
    launch(16'h00FE, 16'h00FF);
    wait_done(cyc, bb);
    chk("b2b_first", {cyc[27:0], G, L, E, done}, {28'd8, 1'b0, 1'b1, 1'b0, 1'b1});
    launch_now(16'h0003, 16'h0001);
    chk("b2b_clear", {28'd0, busy, G, L, E}, 32'h8);
    wait_done(cyc, bb);
    chk("b2b_lat", cyc, 8);
    chk("b2b_flags", {29'd0, G, L, E}, 32'h4);

    // start pulsed during RUN is ignored, single done pulse
    launch(16'h0000, 16'h0001);
    ndone = 0;
    first = -1;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) begin
        start = 1'b1;
        x     = 16'hFFFF;
        y     = 16'h0000;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (first < 0) first = c;
      end
    end
    chk("ign_lat", first, 8);
    chk("ign_pulses", ndone, 1);
    chk("ign_flags", {29'd0, G, L, E}, 32'h2);

    // Async reset in IDLE clears held flags
    #3 rst = 1'b1;
    #1;
    chk("rst_idle", {27'd0, busy, done, G, L, E}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-RUN aborts without a done pulse
    launch(16'hAAAA, 16'hAAAA);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_prebusy", {31'd0, busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_run", {27'd0, busy, done, G, L, E}, 32'h0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    chk("rst_nodone", ndone, 0);
    @(negedge clk);
    rst = 1'b0;
    check_op("s5_after", vt[0]);

`ifdef SEQ_MAG_COMP_SIGNED_EN
    check_op("sg1", '{16'hFFFF, 16'h0001, 1, 1'b0, 1'b1, 1'b0});
    check_op("sg2", '{16'hFFFE, 16'hFFFF, 8, 1'b0, 1'b1, 1'b0});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
